// File: rtl/gcnt_alarm_iom.sv
// Multi-channel alarm comparator against a free-running global count, with an MCS IO bus
// register interface, wrap-safe compare, periodic reload and an atomic 2-word count read.
module gcnt_alarm_iom #(
    parameter int unsigned COUNT_BITS = 56,
    parameter int unsigned NUM_CH     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [COUNT_BITS-1:0] count,
    input  logic                  io_addr_strobe,
    input  logic                  io_read_strobe,
    input  logic                  io_write_strobe,
    input  logic [11:0]           io_address,
    input  logic [3:0]            io_byte_enable,
    input  logic [31:0]           io_write_data,
    output logic [31:0]           io_read_data,
    output logic                  io_ready,
    output logic [NUM_CH-1:0]     alarm,
    output logic                  irq
);

    localparam int unsigned HI_BITS = COUNT_BITS - 32;
    localparam logic [COUNT_BITS-1:0] HALF = {1'b1, {(COUNT_BITS-1){1'b0}}};

    logic [COUNT_BITS-1:0] cmp_q    [NUM_CH];
    logic [31:0]           period_q [NUM_CH];
    logic [NUM_CH-1:0]     en_q, periodic_q, ie_q, pending_q, alarm_q;
    logic [HI_BITS-1:0]    shadow_q;
    logic [31:0]           rdata_q, rdata_d;
    logic                  ready_q, irq_q;

    logic [COUNT_BITS-1:0] diff [NUM_CH];
    logic [NUM_CH-1:0]     due, w1c;
    logic                  rd_en, wr_en, ch_space, status_hit, cnt_lo_hit, cnt_hi_hit;
    logic [3:0]            ch_sel;
    logic [1:0]            reg_sel;

    assign rd_en      = io_addr_strobe & io_read_strobe;
    assign wr_en      = io_addr_strobe & io_write_strobe & (io_byte_enable == 4'hF);
    assign ch_space   = (io_address[11:8] == 4'h0) && (io_address[1:0] == 2'b00);
    assign ch_sel     = io_address[7:4];
    assign reg_sel    = io_address[3:2];
    assign status_hit = (io_address == 12'h100);
    assign cnt_lo_hit = (io_address == 12'h104);
    assign cnt_hi_hit = (io_address == 12'h108);
    assign w1c        = (wr_en && status_hit) ? io_write_data[NUM_CH-1:0] : '0;

    // (count - cmp) below half-range means cmp is at or behind count: wrap-safe "due".
    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            diff[n] = count - cmp_q[n];
            due[n]  = en_q[n] & (diff[n] < HALF);
        end
    end

    always_comb begin
        rdata_d = '0;
        if (ch_space) begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (ch_sel == 4'(n)) begin
                    case (reg_sel)
                        2'd0:    rdata_d = cmp_q[n][31:0];
                        2'd1:    rdata_d = 32'(cmp_q[n][COUNT_BITS-1:32]);
                        2'd2:    rdata_d = period_q[n];
                        default: rdata_d = {29'b0, ie_q[n], periodic_q[n], en_q[n]};
                    endcase
                end
            end
        end else if (status_hit) begin
            rdata_d = 32'(pending_q);
        end else if (cnt_lo_hit) begin
            rdata_d = count[31:0];
        end else if (cnt_hi_hit) begin
            rdata_d = 32'(shadow_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NUM_CH; n++) begin
                cmp_q[n]    <= '0;
                period_q[n] <= '0;
            end
            en_q       <= '0;
            periodic_q <= '0;
            ie_q       <= '0;
            pending_q  <= '0;
            alarm_q    <= '0;
            shadow_q   <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ready_q   <= io_addr_strobe;
            rdata_q   <= rd_en ? rdata_d : '0;
            alarm_q   <= due;
            pending_q <= (pending_q & ~w1c) | due;
            irq_q     <= |(pending_q & ie_q);
            if (rd_en && cnt_lo_hit) begin
                shadow_q <= count[COUNT_BITS-1:32];
            end
            for (int n = 0; n < NUM_CH; n++) begin
                if (due[n]) begin
                    if (periodic_q[n] && (period_q[n] != 32'd0)) begin
                        cmp_q[n] <= cmp_q[n] + COUNT_BITS'(period_q[n]);
                    end else begin
                        en_q[n] <= 1'b0;
                    end
                end
                // CPU writes come last so they override the hardware update above.
                if (wr_en && ch_space && (ch_sel == 4'(n))) begin
                    case (reg_sel)
                        2'd0:    cmp_q[n][31:0] <= io_write_data;
                        2'd1:    cmp_q[n][COUNT_BITS-1:32] <= io_write_data[HI_BITS-1:0];
                        2'd2:    period_q[n] <= io_write_data;
                        default: begin
                            en_q[n]       <= io_write_data[0];
                            periodic_q[n] <= io_write_data[1];
                            ie_q[n]       <= io_write_data[2];
                        end
                    endcase
                end
            end
        end
    end

    assign io_read_data = rdata_q;
    assign io_ready     = ready_q;
    assign alarm        = alarm_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_gcnt_alarm_iom.sv
// Directed bench for gcnt_alarm_iom: one-shot, periodic, wrap, atomic count read,
// collisions and reset, all against hand-computed expectations.
module tb_gcnt_alarm_iom;

    localparam int unsigned COUNT_BITS = 56;
    localparam int unsigned NUM_CH     = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [COUNT_BITS-1:0] count = '0;
    logic                  io_addr_strobe = 1'b0;
    logic                  io_read_strobe = 1'b0;
    logic                  io_write_strobe = 1'b0;
    logic [11:0]           io_address = '0;
    logic [3:0]            io_byte_enable = '0;
    logic [31:0]           io_write_data = '0;
    logic [31:0]           io_read_data;
    logic                  io_ready;
    logic [NUM_CH-1:0]     alarm;
    logic                  irq;

    int   total = 0;
    int   bad = 0;
    logic run = 1'b0;
    logic [COUNT_BITS-1:0] fires [$];
    logic [31:0] rd;

    gcnt_alarm_iom #(
        .COUNT_BITS(COUNT_BITS),
        .NUM_CH    (NUM_CH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .count          (count),
        .io_addr_strobe (io_addr_strobe),
        .io_read_strobe (io_read_strobe),
        .io_write_strobe(io_write_strobe),
        .io_address     (io_address),
        .io_byte_enable (io_byte_enable),
        .io_write_data  (io_write_data),
        .io_read_data   (io_read_data),
        .io_ready       (io_ready),
        .alarm          (alarm),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (run) count = count + 1'b1;
    endtask

    task automatic bus_wr(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] be);
        io_addr_strobe  = 1'b1;
        io_write_strobe = 1'b1;
        io_address      = addr;
        io_write_data   = data;
        io_byte_enable  = be;
        cyc();
        check_eq("wr_ready", 64'(io_ready), 64'd1);
        io_addr_strobe  = 1'b0;
        io_write_strobe = 1'b0;
    endtask

    task automatic bus_rd(input logic [11:0] addr, output logic [31:0] data);
        io_addr_strobe = 1'b1;
        io_read_strobe = 1'b1;
        io_address     = addr;
        cyc();
        check_eq("rd_ready", 64'(io_ready), 64'd1);
        data           = io_read_data;
        io_addr_strobe = 1'b0;
        io_read_strobe = 1'b0;
    endtask

    // Records the count value seen at each edge that produced an alarm pulse on channel ch.
    task automatic collect(input int ch, input int n);
        logic [COUNT_BITS-1:0] c;
        fires.delete();
        for (int i = 0; i < n; i++) begin
            c = count;
            cyc();
            if (alarm[ch]) fires.push_back(c);
        end
    endtask

    function automatic logic [63:0] fire_at(input int i);
        return (fires.size() > i) ? 64'(fires[i]) : 64'hDEAD;
    endfunction

    initial begin
        count = 56'd100;
        #12;
        check_eq("rst_ready", 64'(io_ready), 64'd0);
        check_eq("rst_rdata", 64'(io_read_data), 64'd0);
        check_eq("rst_alarm", 64'(alarm), 64'd0);
        check_eq("rst_irq", 64'(irq), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus_rd(12'h100, rd);
        check_eq("rst_status", 64'(rd), 64'd0);

        // One-shot on channel 0 with IE
        bus_wr(12'h000, 32'd105, 4'hF);
        bus_wr(12'h004, 32'd0, 4'hF);
        bus_wr(12'h00C, 32'h5, 4'hF);
        run = 1'b1;
        collect(0, 10);
        check_eq("os_nfires", 64'(fires.size()), 64'd1);
        check_eq("os_fire_at", fire_at(0), 64'd105);
        check_eq("os_irq", 64'(irq), 64'd1);
        check_eq("idle_rdata", 64'(io_read_data), 64'd0);
        check_eq("idle_ready", 64'(io_ready), 64'd0);
        run = 1'b0;
        bus_rd(12'h100, rd);
        check_eq("os_status", 64'(rd), 64'd1);
        bus_rd(12'h00C, rd);
        check_eq("os_ctrl", 64'(rd), 64'h4);
        bus_rd(12'h0F0, rd);
        check_eq("unmapped_rd", 64'(rd), 64'd0);

        // Periodic on channel 0, IE=0
        bus_wr(12'h100, 32'hF, 4'hF);
        count = 56'd190;
        bus_wr(12'h000, 32'd200, 4'hF);
        bus_wr(12'h008, 32'd50, 4'hF);
        bus_wr(12'h00C, 32'h3, 4'hF);
        run = 1'b1;
        collect(0, 120);
        check_eq("per_nfires", 64'(fires.size()), 64'd3);
        check_eq("per_fire0", fire_at(0), 64'd200);
        check_eq("per_fire1", fire_at(1), 64'd250);
        check_eq("per_fire2", fire_at(2), 64'd300);
        check_eq("per_irq", 64'(irq), 64'd0);
        run = 1'b0;
        bus_rd(12'h100, rd);
        check_eq("per_status", 64'(rd), 64'h1);
        bus_wr(12'h00C, 32'h0, 4'hF);
        bus_wr(12'h008, 32'h0, 4'hF);

        // Wrap: cmp=2 while count is just below 2^56
        bus_wr(12'h100, 32'hF, 4'hF);
        count = {COUNT_BITS{1'b1}} - 56'd3;
        bus_wr(12'h000, 32'd2, 4'hF);
        bus_wr(12'h004, 32'd0, 4'hF);
        bus_wr(12'h00C, 32'h1, 4'hF);
        run = 1'b1;
        collect(0, 10);
        check_eq("wrap_nfires", 64'(fires.size()), 64'd1);
        check_eq("wrap_fire_at", fire_at(0), 64'd2);
        run = 1'b0;
        count = 56'd1000;
        bus_wr(12'h000, 32'd990, 4'hF);
        bus_wr(12'h00C, 32'h1, 4'hF);
        collect(0, 1);
        check_eq("past_nfires", 64'(fires.size()), 64'd1);
        check_eq("past_fire_at", fire_at(0), 64'd1000);

        // Atomic two-word count read across a carry
        count = 56'h00FF_FFFF_FFFF_FFFF;
        bus_rd(12'h104, rd);
        check_eq("cnt_lo", 64'(rd), 64'hFFFF_FFFF);
        count = count + 1'b1;
        bus_rd(12'h108, rd);
        check_eq("cnt_hi_shadow", 64'(rd), 64'h00FF_FFFF);
        bus_rd(12'h104, rd);
        check_eq("cnt_lo_after", 64'(rd), 64'd0);

        // Collision: W1C of STATUS on the same edge as a fire
        bus_wr(12'h100, 32'hF, 4'hF);
        count = 56'd500;
        bus_wr(12'h000, 32'd502, 4'hF);
        bus_wr(12'h00C, 32'h1, 4'hF);
        run = 1'b1;
        cyc();
        cyc();
        bus_wr(12'h100, 32'h1, 4'hF);
        check_eq("coll_alarm", 64'(alarm[0]), 64'd1);
        run = 1'b0;
        bus_rd(12'h100, rd);
        check_eq("coll_status", 64'(rd), 64'h1);
        bus_wr(12'h018, 32'h1234, 4'h3);
        bus_rd(12'h018, rd);
        check_eq("be_period", 64'(rd), 64'd0);
        bus_wr(12'h01C, 32'h7, 4'h3);
        bus_rd(12'h01C, rd);
        check_eq("be_ctrl", 64'(rd), 64'd0);

        // Reset during a periodic run, mid-transfer
        bus_wr(12'h100, 32'hF, 4'hF);
        count = 56'd0;
        bus_wr(12'h000, 32'd5, 4'hF);
        bus_wr(12'h008, 32'd3, 4'hF);
        bus_wr(12'h00C, 32'h7, 4'hF);
        run = 1'b1;
        collect(0, 12);
        check_eq("pre_rst_nfires", 64'(fires.size()), 64'd3);
        check_eq("pre_rst_irq", 64'(irq), 64'd1);
        check_eq("pre_rst_alarm", 64'(alarm[0]), 64'd1);
        #2;
        io_addr_strobe = 1'b1;
        io_read_strobe = 1'b1;
        io_address     = 12'h100;
        rst_n          = 1'b0;
        #1;
        check_eq("rst_now_alarm", 64'(alarm), 64'd0);
        check_eq("rst_now_irq", 64'(irq), 64'd0);
        check_eq("rst_now_ready", 64'(io_ready), 64'd0);
        check_eq("rst_now_rdata", 64'(io_read_data), 64'd0);
        @(posedge clk);
        #1;
        check_eq("rst_abort_ready", 64'(io_ready), 64'd0);
        io_addr_strobe = 1'b0;
        io_read_strobe = 1'b0;
        rst_n          = 1'b1;
        collect(0, 30);
        check_eq("post_rst_nfires", 64'(fires.size()), 64'd0);
        check_eq("post_rst_irq", 64'(irq), 64'd0);
        run = 1'b0;
        bus_rd(12'h00C, rd);
        check_eq("post_rst_ctrl", 64'(rd), 64'd0);
        bus_rd(12'h100, rd);
        check_eq("post_rst_status", 64'(rd), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gcnt_alarm_iom.md
GCNT_ALARM_IOM -- requirements
Module: gcnt_alarm_iom

Interface
REQ-001 The block SHALL have parameter COUNT_BITS, default 56, giving the width of the global count compared against (legal range 33..64).
REQ-002 The block SHALL have parameter NUM_CH, default 4, giving the number of alarm channels (legal range 1..8).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port count, input, COUNT_BITS bits: free-running global count, synchronous to clk.
REQ-006 The block SHALL have ports io_addr_strobe, io_read_strobe and io_write_strobe, inputs, 1 bit each: MCS IO bus qualifiers.
REQ-007 The block SHALL have port io_address, input, 12 bits: byte address.
REQ-008 The block SHALL have port io_byte_enable, input, 4 bits: write lane enables.
REQ-009 The block SHALL have port io_write_data, input, 32 bits: write data.
REQ-010 The block SHALL have port io_read_data, output, 32 bits: registered read data.
REQ-011 The block SHALL have port io_ready, output, 1 bit: single-cycle transfer acknowledge.
REQ-012 The block SHALL have port alarm, output, NUM_CH bits: one-cycle pulse per channel on fire.
REQ-013 The block SHALL have port irq, output, 1 bit: level interrupt.

Function
REQ-014 Channel n registers SHALL sit at base n*0x10: +0x0 CMP_LO (cmp[31:0]), +0x4 CMP_HI (cmp[COUNT_BITS-1:32], excess bits ignored and read 0), +0x8 PERIOD (32 bits), +0xC CTRL (bit0 EN, bit1 PERIODIC, bit2 IE).
REQ-015 Global registers SHALL be: 0x100 STATUS (pending[NUM_CH-1:0], write-1-to-clear), 0x104 CNT_LO, 0x108 CNT_HI.
REQ-016 io_ready SHALL assert exactly one cycle after any cycle with io_addr_strobe=1, for reads, writes, and unmapped addresses alike.
REQ-017 io_read_data SHALL be registered, SHALL be valid in the io_ready cycle, and SHALL be 0 in all other cycles and for unmapped addresses.
REQ-018 A write SHALL take effect only when io_byte_enable=4'hF; any other value SHALL still be acknowledged but SHALL have no effect.
REQ-019 A read of CNT_LO SHALL return count[31:0] and latch count[COUNT_BITS-1:32] into a shadow register in the same cycle; CNT_HI SHALL return that shadow, giving an atomic 2-word read.
REQ-020 Channel n SHALL be due when EN=1 and the MSB of (count - cmp) modulo 2^COUNT_BITS is 0; this makes the compare wrap-safe, and a compare value already in the past fires immediately.
REQ-021 On a due cycle, channel n SHALL, in the following cycle: pulse alarm[n] high for one cycle and set pending[n].
REQ-022 On a due cycle with PERIODIC=1 and PERIOD!=0, channel n SHALL set cmp <= cmp + PERIOD (modulo 2^COUNT_BITS) and keep EN=1.
REQ-023 On a due cycle otherwise (one-shot, or PERIOD=0), channel n SHALL clear EN.
REQ-024 If cmp is still due after a periodic reload (catch-up), the channel SHALL fire again on successive cycles until no longer due; no fire SHALL be dropped or merged.
REQ-025 irq SHALL equal the registered OR over n of (pending[n] AND IE[n]).
REQ-026 A CPU write to CMP_*, CTRL, or PERIOD in the same cycle as a fire SHALL take precedence over the hardware update of that register, but pending and alarm SHALL still be produced.
REQ-027 When a STATUS W1C and a new fire hit the same channel in the same cycle, the set SHALL win and pending SHALL remain 1.
REQ-028 Writing CMP_LO/CMP_HI SHALL NOT change EN; software SHALL write CMP before setting EN.

Reset
REQ-029 While rst_n=0, the block SHALL asynchronously force all cmp, PERIOD, CTRL, pending and shadow registers, io_read_data, io_ready, alarm and irq to 0.
REQ-030 A reset asserted mid-transfer SHALL abort the transfer with no io_ready.
REQ-031 After rst_n deasserts, no channel SHALL fire until software sets EN.

Verification
REQ-032 Bench SHALL cover one-shot: count=100, write CMP=105, CTRL=0x5 -> alarm[0] pulses one cycle after count=105; pending[0]=1; irq=1; EN reads 0.
REQ-033 Bench SHALL cover periodic: CMP=200, PERIOD=50, CTRL=0x3 -> fires at 200, 250 and 300; irq stays 0 (IE=0); STATUS reads 0x1.
REQ-034 Bench SHALL cover wrap: COUNT_BITS=56, count=2^56-4, CMP=2 -> no fire until count wraps to 2; a past CMP of count-10 fires on the next cycle.
REQ-035 Bench SHALL cover the atomic read: read CNT_LO while count=0x00FF_FFFF_FFFF_FFFF, then read CNT_HI after a carry -> CNT_HI returns 0x00FF_FFFF.
REQ-036 Bench SHALL cover collisions: W1C of STATUS coincident with a fire -> pending stays 1; a write with byte_enable=4'h3 -> register unchanged and io_ready=1.
REQ-037 Bench SHALL cover reset: rst_n=0 during a periodic run -> all outputs 0 immediately and no alarm after release.
